// File: rtl/div_ctrl.sv
// Multi-cycle 32-bit divider (DIV/DIVU) for the EX stage: one restoring step per cycle.
// Optional macro DIV_ZERO_CHECK_EN adds a short-circuit path for a zero divisor.
module div_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o,
    output logic        stallreq_o
);

    // state     | meaning
    // ST_FREE   | idle, waiting for start_i
    // ST_BYZERO | zero divisor seen at capture (DIV_ZERO_CHECK_EN only)
    // ST_ON     | 32 shift-subtract steps in progress
    // ST_END    | result presented, held while start_i stays high
`ifdef DIV_ZERO_CHECK_EN
    typedef enum logic [1:0] {
        ST_FREE   = 2'd0,
        ST_BYZERO = 2'd1,
        ST_ON     = 2'd2,
        ST_END    = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_FREE   = 2'd0,
        ST_ON     = 2'd2,
        ST_END    = 2'd3
    } state_t;
`endif

    state_t      state_q;
    logic [4:0]  cnt_q;
    logic [64:0] work_q;
    logic [31:0] divisor_q;
    logic        neg_quo_q;
    logic        neg_rem_q;

    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [32:0] diff;
    logic [64:0] work_step_d;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    assign abs_a = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
    assign abs_b = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;

    // Working register: remainder in [64:33], quotient bits shift in at [0].
    // A borrow out of the trial subtraction means the partial remainder is below the divisor.
    assign diff        = {1'b0, work_q[63:32]} - {1'b0, divisor_q};
    assign work_step_d = diff[32] ? {work_q[63:0], 1'b0}
                                  : {diff[31:0], work_q[31:0], 1'b1};

    assign quo     = work_q[31:0];
    assign rem     = work_q[64:33];
    assign quo_fix = neg_quo_q ? (~quo + 32'd1) : quo;
    assign rem_fix = neg_rem_q ? (~rem + 32'd1) : rem;

    assign stallreq_o = start_i & ~ready_o & ~annul_i;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_FREE;
            cnt_q     <= 5'd0;
            work_q    <= 65'd0;
            divisor_q <= 32'd0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_o  <= 64'd0;
            ready_o   <= 1'b0;
        end else begin
            case (state_q)
                ST_FREE: begin
                    ready_o  <= 1'b0;
                    result_o <= 64'd0;
                    if (start_i && !annul_i) begin
                        divisor_q <= abs_b;
                        neg_quo_q <= signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
                        neg_rem_q <= signed_div_i & opdata1_i[31];
                        work_q    <= {32'd0, abs_a, 1'b0};
                        cnt_q     <= 5'd0;
`ifdef DIV_ZERO_CHECK_EN
                        if (opdata2_i == 32'd0) begin
                            state_q <= ST_BYZERO;
                        end else begin
                            state_q <= ST_ON;
                        end
`else
                        state_q <= ST_ON;
`endif
                    end
                end
`ifdef DIV_ZERO_CHECK_EN
                ST_BYZERO: begin
                    work_q <= 65'd0;
                    if (annul_i) begin
                        state_q <= ST_FREE;
                    end else begin
                        state_q <= ST_END;
                    end
                end
`endif
                ST_ON: begin
                    if (annul_i) begin
                        state_q <= ST_FREE;
                        cnt_q   <= 5'd0;
                    end else begin
                        work_q <= work_step_d;
                        cnt_q  <= cnt_q + 5'd1;
                        if (cnt_q == 5'd31) begin
                            state_q <= ST_END;
                        end
                    end
                end
                ST_END: begin
                    // Result is recomputed from the frozen working register, so it stays stable.
                    if (start_i) begin
                        ready_o  <= 1'b1;
                        result_o <= {rem_fix, quo_fix};
                    end else begin
                        ready_o  <= 1'b0;
                        result_o <= 64'd0;
                        state_q  <= ST_FREE;
                    end
                end
                default: begin
                    state_q <= ST_FREE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: directed cases plus randomized operands against an arithmetic model.
module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;
    logic        stallreq;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    div_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (op1),
        .opdata2_i    (op2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready),
        .stallreq_o   (stallreq)
    );

    // Reference: divide magnitudes with plain arithmetic, then apply the sign rules.
    function automatic logic [63:0] model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint unsigned ma, mb, q, r;
        bit na, nb;
        logic [63:0] qv, rv;
        na = sgn && a[31];
        nb = sgn && b[31];
        ma = na ? (64'h1_0000_0000 - {32'd0, a}) : {32'd0, a};
        mb = nb ? (64'h1_0000_0000 - {32'd0, b}) : {32'd0, b};
        if (mb == 0) begin
`ifdef DIV_ZERO_CHECK_EN
            return 64'd0;
`else
            q = 64'hFFFF_FFFF;
            r = ma;
`endif
        end else begin
            q = ma / mb;
            r = ma % mb;
        end
        if (na ^ nb) q = -q;
        if (na) r = -r;
        qv = q;
        rv = r;
        return {rv[31:0], qv[31:0]};
    endfunction

    function automatic int model_lat(input logic [31:0] b);
`ifdef DIV_ZERO_CHECK_EN
        if (b == 32'd0) return 2;
`endif
        return 33;
    endfunction

    // Caller must be at a negedge. Returns edges from acceptance to first ready, and the result.
    task automatic run_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                           output int lat, output logic [63:0] res, output int stall_bad);
        int cyc;
        stall_bad  = 0;
        lat        = -1;
        res        = 'x;
        signed_div = sgn;
        op1        = a;
        op2        = b;
        start      = 1'b1;
        annul      = 1'b0;
        #1;
        if (stallreq !== 1'b1) stall_bad++;
        cyc = 0;
        while (cyc < 100) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (ready === 1'b1) begin
                lat = cyc - 1;
                res = result;
                if (stallreq !== 1'b0) stall_bad++;
                break;
            end
            if (stallreq !== 1'b1) stall_bad++;
            op1 = $urandom;
            op2 = $urandom;
        end
    endtask

    task automatic drop_start();
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; annul = 1'b0; signed_div = 1'b0; op1 = '0; op2 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", ready); end
        n_checks++;
        if (result !== 64'd0) begin n_fail++; $display("FAIL reset_result got %h want 0", result); end
        n_checks++;
        if (stallreq !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", stallreq); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_unsigned_basic();
        int lat, sb;
        logic [63:0] res;
        run_div(1'b0, 32'd100, 32'd7, lat, res, sb);
        n_checks++;
        if (lat !== 33) begin n_fail++; $display("FAIL u100_7_latency got %0d want 33", lat); end
        n_checks++;
        if (res !== 64'h00000002_0000000E) begin n_fail++; $display("FAIL u100_7_result got %h want 000000020000000e", res); end
        n_checks++;
        if (sb !== 0) begin n_fail++; $display("FAIL u100_7_stall got %0d bad cycles want 0", sb); end
        drop_start();
        n_checks++;
        if (ready !== 1'b0 || result !== 64'd0) begin
            n_fail++; $display("FAIL u100_7_release got ready=%b result=%h want 0/0", ready, result);
        end
    endtask

    task automatic test_signed();
        int lat, sb;
        logic [63:0] res;
        run_div(1'b1, -32'sd7, 32'd2, lat, res, sb);
        n_checks++;
        if (res !== 64'hFFFFFFFF_FFFFFFFD) begin n_fail++; $display("FAIL s_m7_2_result got %h want fffffffffffffffd", res); end
        n_checks++;
        if (lat !== 33) begin n_fail++; $display("FAIL s_m7_2_latency got %0d want 33", lat); end
        drop_start();
        run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, lat, res, sb);
        n_checks++;
        if (res !== 64'h00000000_80000000) begin n_fail++; $display("FAIL s_overflow_result got %h want 0000000080000000", res); end
        drop_start();
    endtask

    task automatic test_div_zero();
        int lat, sb;
        logic [63:0] res;
        logic [63:0] exp_s;
        run_div(1'b0, 32'd5, 32'd0, lat, res, sb);
`ifdef DIV_ZERO_CHECK_EN
        n_checks++;
        if (lat !== 2) begin n_fail++; $display("FAIL u5_0_latency got %0d want 2", lat); end
        n_checks++;
        if (res !== 64'd0) begin n_fail++; $display("FAIL u5_0_result got %h want 0", res); end
`else
        n_checks++;
        if (lat !== 33) begin n_fail++; $display("FAIL u5_0_latency got %0d want 33", lat); end
        n_checks++;
        if (res !== 64'h00000005_FFFFFFFF) begin n_fail++; $display("FAIL u5_0_result got %h want 00000005ffffffff", res); end
`endif
        drop_start();
        exp_s = model(1'b1, -32'sd5, 32'd0);
        run_div(1'b1, -32'sd5, 32'd0, lat, res, sb);
        n_checks++;
        if (res !== exp_s) begin n_fail++; $display("FAIL s_m5_0_result got %h want %h", res, exp_s); end
        drop_start();
    endtask

    task automatic test_annul();
        int lat, sb, ready_seen;
        logic [63:0] res;
        ready_seen = 0;
        signed_div = 1'b0; op1 = 32'd100; op2 = 32'd7; start = 1'b1; annul = 1'b0;
        @(posedge clk);
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
            if (ready === 1'b1) ready_seen++;
        end
        annul = 1'b1;
        #1;
        n_checks++;
        if (stallreq !== 1'b0) begin n_fail++; $display("FAIL annul_stall got %b want 0", stallreq); end
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        annul = 1'b0;
        n_checks++;
        if (ready !== 1'b0 || result !== 64'd0) begin
            n_fail++; $display("FAIL annul_outputs got ready=%b result=%h want 0/0", ready, result);
        end
        repeat (30) begin
            @(posedge clk);
            @(negedge clk);
            if (ready === 1'b1) ready_seen++;
        end
        n_checks++;
        if (ready_seen !== 0) begin n_fail++; $display("FAIL annul_ready_seen got %0d want 0", ready_seen); end
        run_div(1'b0, 32'd9, 32'd3, lat, res, sb);
        n_checks++;
        if (res !== 64'h00000000_00000003) begin n_fail++; $display("FAIL annul_9_3_result got %h want 0000000000000003", res); end
        n_checks++;
        if (lat !== 33) begin n_fail++; $display("FAIL annul_9_3_latency got %0d want 33", lat); end
        drop_start();
    endtask

    task automatic test_reset_mid();
        int lat, sb, ready_seen;
        logic [63:0] res;
        ready_seen = 0;
        signed_div = 1'b0; op1 = 32'd100; op2 = 32'd7; start = 1'b1; annul = 1'b0;
        @(posedge clk);
        repeat (20) @(posedge clk);
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (ready !== 1'b0 || result !== 64'd0 || stallreq !== 1'b0) begin
            n_fail++; $display("FAIL midreset_outputs got ready=%b result=%h stall=%b want 0/0/0", ready, result, stallreq);
        end
        rst = 1'b1;
        repeat (20) begin
            @(posedge clk);
            @(negedge clk);
            if (ready === 1'b1) ready_seen++;
        end
        n_checks++;
        if (ready_seen !== 0) begin n_fail++; $display("FAIL midreset_ready_seen got %0d want 0", ready_seen); end
        run_div(1'b0, 32'd100, 32'd7, lat, res, sb);
        n_checks++;
        if (lat !== 33) begin n_fail++; $display("FAIL midreset_latency got %0d want 33", lat); end
        n_checks++;
        if (res !== 64'h00000002_0000000E) begin n_fail++; $display("FAIL midreset_result got %h want 000000020000000e", res); end
        drop_start();
    endtask

    task automatic test_hold_end();
        int lat, sb, bad;
        logic [63:0] res, exp;
        bad = 0;
        exp = model(1'b1, 32'd1000, -32'sd3);
        run_div(1'b1, 32'd1000, -32'sd3, lat, res, sb);
        n_checks++;
        if (res !== exp) begin n_fail++; $display("FAIL hold_result got %h want %h", res, exp); end
        for (int i = 0; i < 5; i++) begin
            annul = (i == 1 || i == 2);
            @(posedge clk);
            @(negedge clk);
            if (ready !== 1'b1 || result !== exp) bad++;
        end
        annul = 1'b0;
        n_checks++;
        if (bad !== 0) begin n_fail++; $display("FAIL hold_stable got %0d unstable cycles want 0", bad); end
        drop_start();
        n_checks++;
        if (ready !== 1'b0 || result !== 64'd0) begin
            n_fail++; $display("FAIL hold_release got ready=%b result=%h want 0/0", ready, result);
        end
    endtask

    task automatic test_back_to_back();
        int lat, sb;
        logic [63:0] res, exp;
        logic [31:0] a, b;
        for (int i = 0; i < 3; i++) begin
            a = $urandom;
            b = $urandom_range(1, 1000);
            exp = model(1'b0, a, b);
            run_div(1'b0, a, b, lat, res, sb);
            n_checks++;
            if (res !== exp || lat !== 33) begin
                n_fail++; $display("FAIL b2b_%0d got %h lat %0d want %h lat 33", i, res, lat, exp);
            end
            drop_start();
        end
    endtask

    task automatic test_random();
        int lat, sb, sel;
        bit sgn;
        logic [63:0] res, exp;
        logic [31:0] a, b;
        for (int i = 0; i < 40; i++) begin
            sgn = 1'($urandom);
            a   = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            sel = $urandom_range(0, 5);
            case (sel)
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 15);
                2:       b = 32'hFFFFFFFF;
                default: b = $urandom;
            endcase
            exp = model(sgn, a, b);
            run_div(sgn, a, b, lat, res, sb);
            n_checks++;
            if (res !== exp) begin
                n_fail++; $display("FAIL rand_%0d_result s=%0d a=%h b=%h got %h want %h", i, sgn, a, b, res, exp);
            end
            n_checks++;
            if (lat !== model_lat(b) || sb !== 0) begin
                n_fail++; $display("FAIL rand_%0d_timing got lat %0d stallbad %0d want lat %0d stallbad 0", i, lat, sb, model_lat(b));
            end
            drop_start();
        end
    endtask

    initial begin
        test_reset();
        test_unsigned_basic();
        test_signed();
        test_div_zero();
        test_annul();
        test_reset_mid();
        test_hold_end();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
